// File: rtl/nto1_fifo_pkg.sv
// Shared types and helpers for the N-to-1 FIFO write path (scheduler and FIFO).
// Width helpers let each instance derive its level/pointer widths from its own parameters.
package nto1_fifo_pkg;

    localparam int unsigned FIFO_N     = 4;
    localparam int unsigned FIFO_DEPTH = 32;
    localparam int unsigned LEVEL_W    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W      = $clog2(FIFO_N);

    typedef logic [LEVEL_W-1:0] level_t;
    typedef logic [PTR_W-1:0]   ptr_t;

    function automatic int unsigned level_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // A single requester still needs a 1-bit pointer so the port is never zero-width.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned c;
        c = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            c += 32'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/nto1_rr_multigrant.sv
// Combinational rotating-priority selector: grants up to i_k valid requesters,
// scanning from i_ptr upward modulo N, and reports the last index granted.
module nto1_rr_multigrant
    import nto1_fifo_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned PTR_W = 2,
    parameter int unsigned K_W   = 3
) (
    input  logic [N-1:0]     i_valid,
    input  logic [PTR_W-1:0] i_ptr,
    input  logic [K_W-1:0]   i_k,
    output logic [N-1:0]     o_grant,
    output logic [PTR_W-1:0] o_last
);

    logic [PTR_W-1:0] w_idx;
    logic [K_W-1:0]   w_cnt;

    always_comb begin
        o_grant = '0;
        o_last  = i_ptr;
        w_idx   = '0;
        w_cnt   = '0;
        for (int unsigned j = 0; j < N; j++) begin
            w_idx = PTR_W'((32'(i_ptr) + j) % N);
            if (i_valid[w_idx] && (w_cnt < i_k)) begin
                o_grant[w_idx] = 1'b1;
                o_last         = w_idx;
                w_cnt          = w_cnt + K_W'(1);
            end
        end
    end

endmodule

// File: rtl/nto1_fifo_write_scheduler.sv
// Credit-based admission controller for the N-to-1 FIFO write ports.
// Define NTO1_WSCHED_ASSERT_EN to compile in embedded protocol/credit checks.
module nto1_fifo_write_scheduler
    import nto1_fifo_pkg::*;
#(
    parameter int unsigned N          = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 32
) (
    input  logic                               clk_i,
    input  logic                               rst_n_i,
    input  logic [N-1:0]                       req_valid_i,
    input  logic [N-1:0][DATA_WIDTH-1:0]       req_data_i,
    output logic [N-1:0]                       req_ready_o,
    output logic [N-1:0]                       fifo_wr_en_o,
    output logic [N-1:0][DATA_WIDTH-1:0]       fifo_data_o,
    input  logic                               fifo_pop_i,
    output logic [level_width(DEPTH)-1:0]      level_o
);

    localparam int unsigned LVL_W = level_width(DEPTH);
    localparam int unsigned P_W   = ptr_width(N);
    localparam int unsigned K_W   = $clog2(N + 1);

    logic [LVL_W-1:0]                r_level;
    logic [P_W-1:0]                  r_ptr;
    logic [N-1:0]                    r_wr_en;
    logic [N-1:0][DATA_WIDTH-1:0]    r_data;

    logic [LVL_W-1:0] w_free;
    logic [LVL_W-1:0] w_sum;
    logic [LVL_W-1:0] w_level_next;
    logic [K_W-1:0]   w_k;
    logic [N-1:0]     w_sel;
    logic [N-1:0]     w_grant;
    logic [P_W-1:0]   w_last;
    logic [P_W-1:0]   w_ptr_next;

    // Credit comes from the registered level only; a pop frees space one cycle later.
    always_comb begin
        w_free = LVL_W'(DEPTH) - r_level;
        w_k    = (32'(w_free) >= N) ? K_W'(N) : K_W'(w_free);
    end

    nto1_rr_multigrant #(
        .N     (N),
        .PTR_W (P_W),
        .K_W   (K_W)
    ) u_sel (
        .i_valid (req_valid_i),
        .i_ptr   (r_ptr),
        .i_k     (w_k),
        .o_grant (w_sel),
        .o_last  (w_last)
    );

    always_comb begin
        w_grant      = w_sel & {N{rst_n_i}};
        w_sum        = r_level + LVL_W'(popcount(32'(w_grant)));
        w_level_next = (fifo_pop_i && (w_sum != '0)) ? (w_sum - LVL_W'(1)) : w_sum;
        w_ptr_next   = r_ptr;
        if (|w_grant) begin
            w_ptr_next = (32'(w_last) == (N - 1)) ? '0 : (w_last + P_W'(1));
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_level <= '0;
            r_ptr   <= '0;
            r_wr_en <= '0;
            r_data  <= '0;
        end else begin
            r_level <= w_level_next;
            r_ptr   <= w_ptr_next;
            r_wr_en <= w_grant;
            for (int unsigned i = 0; i < N; i++) begin
                if (w_grant[i]) begin
                    r_data[i] <= req_data_i[i];
                end
            end
        end
    end

    assign req_ready_o  = w_grant;
    assign fifo_wr_en_o = r_wr_en;
    assign fifo_data_o  = r_data;
    assign level_o      = r_level;

`ifdef NTO1_WSCHED_ASSERT_EN
    logic [N-1:0]                 r_pend;
    logic [N-1:0][DATA_WIDTH-1:0] r_pend_data;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_pend      <= '0;
            r_pend_data <= '0;
        end else begin
            r_pend      <= req_valid_i & ~w_grant;
            r_pend_data <= req_data_i;
            assert (!(fifo_pop_i && (r_level == '0)))
                else $error("fifo_pop_i asserted while tracked level is 0");
            assert (popcount(32'(w_grant)) <= 32'(w_free))
                else $error("grant count exceeds free credit");
            for (int unsigned i = 0; i < N; i++) begin
                if (r_pend[i]) begin
                    assert (req_valid_i[i] && (req_data_i[i] == r_pend_data[i]))
                        else $error("requester %0d changed valid/data before transfer", i);
                end
            end
        end
    end
`else
    // No embedded checks: a pop at level 0 saturates silently.
`endif

endmodule
